// File: rtl/activation_quant_pipe_pkg.sv
// Shared constants, types and the saturation helper for activation_quant_pipe.
// Optional saturation counter is enabled by ACT_SAT_CNT_EN.
package act_pkg;

   localparam int unsigned WD_DEF        = 8;
   localparam int unsigned FI_DEF        = 3;
   localparam int unsigned CH_DEF        = 8;
   localparam int unsigned FRAME_LEN_DEF = 64;

   localparam int unsigned PSUM_W = 2 * WD_DEF;
   localparam int unsigned CNT_W  = $clog2(FRAME_LEN_DEF) + 1;

   localparam logic signed [PSUM_W:0] SAT_HI = (PSUM_W+1)'(2 ** (WD_DEF - 1) - 1);
   localparam logic signed [PSUM_W:0] SAT_LO = -((PSUM_W+1)'(2 ** (WD_DEF - 1)));

   typedef enum logic {
      ACT_LINEAR = 1'b0,
      ACT_RELU   = 1'b1
   } act_mode_e;

   // Clamps a sign-extended (2*wd+1)-bit value into the signed wd-bit range.
   function automatic logic signed [63:0] sat_wd(input logic signed [63:0] v,
                                                 input int unsigned       wd);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (wd - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (wd - 1));
      if (v > hi)
         sat_wd = hi;
      else if (v < lo)
         sat_wd = lo;
      else
         sat_wd = v;
   endfunction

endpackage

// File: rtl/activation_quant_pipe_lane.sv
// One channel of the requantiser: S1 round/shift/ReLU, S2 saturate to WD bits.
// Optional o_sat (clamp indicator) exists only with ACT_SAT_CNT_EN.
module act_quant_lane
   import act_pkg::*;
#(
   parameter int unsigned WD = WD_DEF,
   parameter int unsigned FI = FI_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_ld1,
   input  logic            i_ld2,
   input  logic [2*WD-1:0] i_psum,
   input  logic            i_relu,
   input  logic            i_rnd,
   output logic [WD-1:0]   o_pix
`ifdef ACT_SAT_CNT_EN
   ,
   output logic            o_sat
`endif
);

   localparam int unsigned PW = 2 * WD;
   localparam logic signed [PW:0] RND_INC = (PW+1)'((2 ** FI) >> 1);

   logic signed [PW:0] w_p;
   logic signed [PW:0] w_t;
   logic signed [PW:0] w_s;
   logic signed [PW:0] r_s;
   act_mode_e          r_mode;
   logic [WD-1:0]      r_pix;
   logic signed [63:0] w_wide;
   logic signed [63:0] w_clamp;
   logic               w_sat;
   logic [WD-1:0]      w_pix;

   always_comb begin
      w_p = signed'({i_psum[PW-1], i_psum});
      w_t = w_p + (i_rnd ? RND_INC : '0);
      w_s = w_t >>> FI;
      if (i_relu && i_psum[PW-1])
         w_s = '0;
   end

   // ReLU results are never negative, so in that mode only the upper clamp can fire.
   always_comb begin
      w_wide  = 64'(r_s);
      w_clamp = sat_wd(w_wide, WD);
      w_sat   = (w_clamp != w_wide);
      w_pix   = w_sat ? w_clamp[WD-1:0] : r_s[WD-1:0];
      if (r_mode == ACT_RELU && r_s[PW])
         w_pix = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s    <= '0;
         r_mode <= ACT_LINEAR;
         r_pix  <= '0;
      end else begin
         if (i_ld1) begin
            r_s    <= w_s;
            r_mode <= act_mode_e'(i_relu);
         end
         if (i_ld2)
            r_pix <= w_pix;
      end
   end

   assign o_pix = r_pix;
`ifdef ACT_SAT_CNT_EN
   assign o_sat = w_sat;
`endif

endmodule

// File: rtl/activation_quant_pipe.sv
// Two-stage multi-channel psum requantiser with valid/ready on both sides and frame-last flag.
// ACT_SAT_CNT_EN adds sat_cnt/sat_clr, a saturating count of clamped channels.
module activation_quant_pipe
   import act_pkg::*;
#(
   parameter int unsigned WD        = WD_DEF,
   parameter int unsigned FI        = FI_DEF,
   parameter int unsigned CH        = CH_DEF,
   parameter int unsigned FRAME_LEN = FRAME_LEN_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [CH*2*WD-1:0] in_psum,
   input  logic               in_relu,
   input  logic               in_rnd,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CH*WD-1:0]   out_ofmap,
   output logic               out_last
`ifdef ACT_SAT_CNT_EN
   ,
   output logic [15:0]        sat_cnt,
   input  logic               sat_clr
`endif
);

   localparam int unsigned CW = $clog2(FRAME_LEN) + 1;

   logic          r_s1_valid;
   logic          r_s2_valid;
   logic [CW-1:0] r_cnt;
   logic          w_ld1;
   logic          w_ld2;
   logic          w_acc;
   logic          w_en2;
   logic          w_emit;
   logic          w_cnt_end;

   assign w_ld2     = !r_s2_valid || out_ready;
   assign w_ld1     = !r_s1_valid || w_ld2;
   assign w_acc     = in_valid && w_ld1;
   assign w_en2     = w_ld2 && r_s1_valid;
   assign w_emit    = r_s2_valid && out_ready;
   assign w_cnt_end = (r_cnt == CW'(FRAME_LEN - 1));

   assign in_ready  = w_ld1;
   assign out_valid = r_s2_valid;
   assign out_last  = w_cnt_end && r_s2_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_cnt      <= '0;
      end else begin
         if (w_ld1)
            r_s1_valid <= in_valid;
         if (w_ld2)
            r_s2_valid <= r_s1_valid;
         if (w_emit)
            r_cnt <= w_cnt_end ? '0 : r_cnt + 1'b1;
      end
   end

`ifdef ACT_SAT_CNT_EN
   logic [CH-1:0] w_sat;
   logic [15:0]   r_sat_cnt;
   logic [16:0]   w_sat_sum;

   always_comb begin
      w_sat_sum = {1'b0, r_sat_cnt};
      for (int unsigned c = 0; c < CH; c++)
         w_sat_sum = w_sat_sum + 17'(w_sat[c]);
   end

   always_ff @(posedge clk) begin
      if (!rst_n || sat_clr)
         r_sat_cnt <= '0;
      else if (w_en2)
         r_sat_cnt <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
   end

   assign sat_cnt = r_sat_cnt;
`endif

   for (genvar c = 0; c < CH; c++) begin : g_lane
      act_quant_lane #(
         .WD(WD),
         .FI(FI)
      ) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .i_ld1 (w_acc),
         .i_ld2 (w_en2),
         .i_psum(in_psum[c*2*WD +: 2*WD]),
         .i_relu(in_relu),
         .i_rnd (in_rnd),
`ifdef ACT_SAT_CNT_EN
         .o_sat (w_sat[c]),
`endif
         .o_pix (out_ofmap[c*WD +: WD])
      );
   end

endmodule

// File: tb/tb_activation_quant_pipe.sv
// Scoreboard bench for activation_quant_pipe (WD=8, FI=3, CH=8, FRAME_LEN=4).
// Define ACT_SAT_CNT_EN to also exercise sat_cnt/sat_clr.
module tb_activation_quant_pipe;

   localparam int unsigned WD = 8;
   localparam int unsigned FI = 3;
   localparam int unsigned CH = 8;
   localparam int unsigned FL = 4;

   logic               clk       = 1'b0;
   logic               rst_n     = 1'b0;
   logic               in_valid  = 1'b0;
   logic               in_ready;
   logic [CH*2*WD-1:0] in_psum   = '0;
   logic               in_relu   = 1'b0;
   logic               in_rnd    = 1'b0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic [CH*WD-1:0]   out_ofmap;
   logic               out_last;
`ifdef ACT_SAT_CNT_EN
   logic [15:0]        sat_cnt;
   logic               sat_clr   = 1'b0;
`endif

   always #5 clk = ~clk;

   activation_quant_pipe #(
      .WD       (WD),
      .FI       (FI),
      .CH       (CH),
      .FRAME_LEN(FL)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_psum  (in_psum),
      .in_relu  (in_relu),
      .in_rnd   (in_rnd),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_ofmap(out_ofmap),
`ifdef ACT_SAT_CNT_EN
      .sat_cnt  (sat_cnt),
      .sat_clr  (sat_clr),
`endif
      .out_last (out_last)
   );

   int n_vec = 0;
   int n_err = 0;
   int frame_pos = 0;
   logic [CH*WD-1:0] sb[$];

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: floor((p + rnd*4) / 8) in real arithmetic, then ReLU and clamp.
   function automatic logic [7:0] q1(input logic [15:0] p, input logic relu, input logic rnd);
      int pi;
      int s;
      logic [31:0] sv;
      pi = int'($signed(p));
      if (relu && pi < 0)
         return 8'h00;
      s = int'($floor(real'(pi + (rnd ? 4 : 0)) / 8.0));
      if (s > 127)  s = 127;
      if (s < -128) s = -128;
      sv = s;
      return sv[7:0];
   endfunction

   function automatic logic [CH*WD-1:0] qv(input logic [CH*2*WD-1:0] p, input logic relu,
                                          input logic rnd);
      logic [CH*WD-1:0] v;
      for (int c = 0; c < CH; c++)
         v[c*8 +: 8] = q1(p[c*16 +: 16], relu, rnd);
      return v;
   endfunction

   function automatic logic [CH*2*WD-1:0] rep(input logic [15:0] x);
      logic [CH*2*WD-1:0] r;
      for (int c = 0; c < CH; c++)
         r[c*16 +: 16] = x;
      return r;
   endfunction

   function automatic logic [CH*2*WD-1:0] rnd_vec();
      logic [CH*2*WD-1:0] r;
      for (int c = 0; c < CH; c++)
         r[c*16 +: 16] = 16'($urandom);
      return r;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         frame_pos = 0;
      end else begin
         if (in_valid && in_ready)
            sb.push_back(qv(in_psum, in_relu, in_rnd));
         if (out_valid && out_ready) begin
            if (sb.size() == 0)
               chk("spurious_out", out_valid, 1'b0);
            else begin
               chk("ofmap", out_ofmap, sb.pop_front());
               chk("last", out_last, frame_pos == FL - 1);
               frame_pos = (frame_pos == FL - 1) ? 0 : frame_pos + 1;
            end
         end
      end
   end

   task automatic wait_acc();
      int k;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready)
         chk("acc_timeout", in_ready, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send(input logic [CH*2*WD-1:0] p, input logic relu, input logic rnd);
      in_psum  = p;
      in_relu  = relu;
      in_rnd   = rnd;
      in_valid = 1'b1;
      wait_acc();
   endtask

   task automatic drain();
      for (int k = 0; k < 50 && sb.size() != 0; k++)
         @(negedge clk);
      chk("drain", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [CH*2*WD-1:0] pa;
      logic [CH*2*WD-1:0] pb;
      logic [CH*2*WD-1:0] pc;

      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_ofmap", out_ofmap, '0);
      chk("rst_last", out_last, 1'b0);
      chk("rst_ready", in_ready, 1'b1);

      // Rounding/truncation and two-cycle latency
      send(rep(16'd100), 1'b0, 1'b1);
      chk("lat_c1", out_valid, 1'b0);
      @(posedge clk);
      #1;
      chk("lat_c2", out_valid, 1'b1);
      chk("pos_rnd", out_ofmap, rep(16'h000D) == rep(16'h000D) ? {CH{8'h0D}} : '0);
      send(rep(16'd100), 1'b0, 1'b0);
      send(rep(-16'sd100), 1'b0, 1'b1);
      send(rep(-16'sd100), 1'b0, 1'b0);
      send(rep(-16'sd100), 1'b1, 1'b1);

      // Saturation extremes mixed with random channels, all mode combinations
      for (int m = 0; m < 4; m++) begin
         pa = rnd_vec();
         pa[15:0]  = 16'h7FFF;
         pa[31:16] = 16'h8000;
         send(pa, m[1], m[0]);
      end
      for (int i = 0; i < 8; i++)
         send(rnd_vec(), 1'($urandom), 1'($urandom));
      drain();

`ifdef ACT_SAT_CNT_EN
      @(posedge clk);
      #1;
      sat_clr = 1'b1;
      @(posedge clk);
      #1;
      sat_clr = 1'b0;
      chk("sat_clr", sat_cnt, 16'd0);
      pa = rep(16'h0000);
      pa[15:0]  = 16'h7FFF;
      pa[31:16] = 16'h8000;
      send(pa, 1'b0, 1'b0);
      drain();
      chk("sat_cnt2", sat_cnt, 16'd2);
      send(pa, 1'b1, 1'b1);
      drain();
      chk("sat_cnt3", sat_cnt, 16'd3);
`endif

      // Back-pressure: two beats fill the pipe, third must wait, output holds
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      pa = rnd_vec();
      pb = rnd_vec();
      pc = rnd_vec();
      send(pa, 1'b0, 1'b1);
      send(pb, 1'b1, 1'b0);
      in_psum  = pc;
      in_relu  = 1'b0;
      in_rnd   = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_ready", in_ready, 1'b0);
         chk("stall_valid", out_valid, 1'b1);
         chk("stall_hold", out_ofmap, qv(pa, 1'b0, 1'b1));
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_acc();
      drain();

      // Continuous stream across frame boundaries
      for (int i = 0; i < 10; i++)
         send(rnd_vec(), 1'($urandom), 1'($urandom));
      drain();

      // Random downstream back-pressure
      fork
         begin
            for (int i = 0; i < 20; i++)
               send(rnd_vec(), 1'($urandom), 1'($urandom));
         end
         begin
            repeat (60) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom);
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset with both stages full discards them and restarts the frame
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      send(rnd_vec(), 1'b0, 1'b1);
      send(rnd_vec(), 1'b0, 1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      chk("rst2_valid", out_valid, 1'b0);
      chk("rst2_ofmap", out_ofmap, '0);
      chk("rst2_last", out_last, 1'b0);
      chk("rst2_ready", in_ready, 1'b1);
      for (int i = 0; i < 6; i++)
         send(rnd_vec(), 1'($urandom), 1'($urandom));
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/activation_quant_pipe.md
Name: activation_quant_pipe

Overview:
- Multi-channel, pipelined successor to the combinational ReLU/truncate stage that sits between the PE-array partial-sum accumulators and the ofmap buffer.
- Takes CH packed 2*WD-bit psums per beat and produces CH WD-bit ofmap pixels.
- Per-beat selectable ReLU or linear activation, and round-half-up or truncation.
- Saturates to the signed WD-bit range; valid/ready handshake on both sides; flags the last pixel of each frame.

Parameters:
- WD, 8, output pixel width; psum width is 2*WD.
- FI, 3, output fraction bits; psum carries 2*FI fraction bits, so the requantise shift is FI.
- CH, 8, channels per beat.
- FRAME_LEN, 64, output beats per frame (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_psum  in  CH*2*WD  packed signed psums; channel c at [c*2*WD +: 2*WD].
- in_relu  in  1  1 = ReLU, 0 = linear; sampled with the beat.
- in_rnd  in  1  1 = round-half-up, 0 = truncate; sampled with the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_ofmap  out  CH*WD  packed signed pixels; channel c at [c*WD +: WD].
- out_last  out  1  beat is the FRAME_LEN-th beat of the frame.

Behaviour:
- Reset (rst_n=0 at a clk edge): all of the following are cleared:
  - out_valid=0, out_ofmap=0, out_last=0;
  - both stage-valid flags, all pipeline data, the frame counter.
- in_ready is combinational, so in_ready=1 during and after reset.
- A reset mid-operation discards in-flight beats; nothing is replayed.
- Handshake:
  - A beat is accepted when in_valid && in_ready; it is emitted when out_valid && out_ready.
  - out_ofmap and out_last hold stable while out_valid && !out_ready.
- Pipeline: two register stages, S1 and S2. S2 drives the outputs.
  - ld2 = !s2_valid || out_ready.
  - ld1 = !s1_valid || ld2.
  - in_ready = ld1, combinational.
  - Full throughput is 1 beat/cycle.
  - Latency is 2 cycles from acceptance to out_valid when not stalled.
  - While stalled, S1 and S2 each hold one beat, and in_ready=0.
- S1 arithmetic, per channel, in 2*WD+1 bits to avoid overflow:
  - t = psum + (in_rnd ? 2^(FI-1) : 0).
  - s = t >>> FI, an arithmetic shift.
  - If in_relu and psum is negative (checked on the original psum), s = 0.
  - S1 registers s, and also carries in_relu for S2.
- S2, per channel: saturate s to [-2^(WD-1), 2^(WD-1)-1] and register the result as the pixel.
  - In ReLU mode the lower bound never triggers.
- Frame counter:
  - Increments on each output handshake.
  - out_last = (count == FRAME_LEN-1) && out_valid.
  - On the handshake of the last beat the counter wraps to 0.
  - FRAME_LEN=1 gives out_last on every beat.
- Modes are per-beat; changing in_relu or in_rnd between beats never corrupts beats already in flight.
- An input beat and an output beat completing in the same cycle is normal pipelined flow, with no bubble.

Optional Feature:
- Macro: ACT_SAT_CNT_EN.
- When defined, adds output port sat_cnt (out, 16 bits) and input port sat_clr (in, 1 bit).
  - sat_cnt counts the channels clamped in S2, summed per beat, on each S2 load.
  - sat_cnt saturates at 16'hFFFF.
  - It is cleared by reset or by sat_clr; sat_clr takes priority over a same-cycle increment.
- When undefined, these ports and their logic are absent, and datapath behaviour is identical.

Decomposition:
- Package act_pkg holds:
  - the localparams PSUM_W = 2*WD and CNT_W = $clog2(FRAME_LEN)+1;
  - the saturation-limit constants;
  - function sat_wd(), which clamps a (2*WD+1)-bit value to WD bits.
- One sub-module, act_quant_lane: the per-channel S1/S2 arithmetic. It is instantiated CH times via generate.
- Handshake control and the frame counter stay in the top module.

Test Plan (WD=8, FI=3):
1. psum=16'sd100 -> pixel 8'h0D (12.5 rounded) with in_rnd=1, 8'h0C with in_rnd=0; out_valid exactly 2 cycles after acceptance.
2. psum=-16'sd100, linear -> 8'hF4 with in_rnd=1, 8'hF3 with in_rnd=0; same psum with ReLU -> 8'h00.
3. psum=16'h7FFF -> 8'h7F; psum=16'h8000, linear -> 8'h80; with ACT_SAT_CNT_EN, one beat with both values in two channels -> sat_cnt=2.
4. Back-to-back beats with out_ready=0 for 5 cycles -> in_ready drops after 2 accepted beats, out_ofmap holds; release -> beats emerge in order, none lost or duplicated.
5. FRAME_LEN=4, 10 continuous beats -> out_last on beats 4 and 8 only; counter wraps cleanly.
6. rst_n=0 for 1 cycle with both stages full -> next cycle out_valid=0, out_ofmap=0, in_ready=1, and out_last does not fire until FRAME_LEN new beats have been emitted.
